// File: rtl/fsm_onehot_chain_if.sv
// rtl/fsm_onehot_chain_if.sv - request/status bundle of the one-hot sequencing FSM
//
// Signals:
//   go        start request in IDLE; continue-looping qualifier at the last stage when wrapping
//   step      step[k-1] advances out of stage Sk
//   abort     forces ERROR from any working stage
//   restart   leaves ERROR to IDLE
//   stage_o   one-hot active stage, zero in IDLE/ERROR
//   busy      high in any working stage
//   done      one-cycle pulse on exit from the last stage
//   err       high while in ERROR
//   err_cause 00 none, 01 abort, 10 timeout, 11 illegal state
//   loop_cnt  completed passes through the last stage, saturating
// Modports: master drives requests and observes status; slave is the FSM.

interface fsm_onehot_chain_if #(
   parameter int N_STAGES = 4,
   parameter int LOOP_W   = 8
);
   logic                go;
   logic [N_STAGES-1:0] step;
   logic                abort;
   logic                restart;
   logic [N_STAGES-1:0] stage_o;
   logic                busy;
   logic                done;
   logic                err;
   logic [1:0]          err_cause;
   logic [LOOP_W-1:0]   loop_cnt;

   modport master (
      output go, step, abort, restart,
      input  stage_o, busy, done, err, err_cause, loop_cnt
   );

   modport slave (
      input  go, step, abort, restart,
      output stage_o, busy, done, err, err_cause, loop_cnt
   );
endinterface

// File: rtl/fsm_onehot_chain.sv
// rtl/fsm_onehot_chain.sv - parametrised one-hot sequencer IDLE -> S1..SN with timeout, abort and recovery
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  fsm_onehot_chain_if.slave: go/step/abort/restart in,
//        stage_o/busy/done/err/err_cause/loop_cnt out (all registered)
// State vector bit 0 is IDLE, bit k is Sk, bit N_STAGES+1 is ERROR.

module fsm_onehot_chain #(
   parameter int N_STAGES = 4,
   parameter int TIMEOUT  = 255,
   parameter int TO_W     = 8,
   parameter int WRAP     = 0,
   parameter int LOOP_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   fsm_onehot_chain_if.slave   bus
);

   localparam int W     = N_STAGES + 2;
   localparam int ERR_B = N_STAGES + 1;

   localparam logic [W-1:0]    ST_IDLE = W'(1);
   localparam logic [W-1:0]    ST_S1   = W'(2);
   localparam logic [W-1:0]    ST_ERR  = {1'b1, {(W-1){1'b0}}};
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

   // Kind of transition taken this cycle; drives the output and counter updates.
   typedef enum logic [2:0] {
      T_HOLD,
      T_START,
      T_ADVANCE,
      T_EXIT,
      T_ABORT,
      T_TIMEOUT,
      T_ILLEGAL,
      T_RESTART
   } xfer_t;

   logic [W-1:0]        cs;
   logic [W-1:0]        ns;
   xfer_t               xfer;
   logic [TO_W-1:0]     dwell;
   logic                legal;
   logic                in_stage;
   logic                step_hit;

   logic [N_STAGES-1:0] stage_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;
   logic [1:0]          cause_r;
   logic [LOOP_W-1:0]   loop_r;

   assign legal    = $onehot(cs);
   assign in_stage = legal && (|cs[N_STAGES:1]);
   // Only the step bit of the current stage can hit, since cs is one-hot here.
   assign step_hit = |(cs[N_STAGES:1] & bus.step);

   always_comb begin
      ns   = cs;
      xfer = T_HOLD;
      if (!legal) begin
         ns   = ST_ERR;
         xfer = T_ILLEGAL;
      end else if (cs[0]) begin
         if (bus.go) begin
            ns   = ST_S1;
            xfer = T_START;
         end
      end else if (cs[ERR_B]) begin
         if (bus.restart) begin
            ns   = ST_IDLE;
            xfer = T_RESTART;
         end
      end else begin
         if (bus.abort) begin
            ns   = ST_ERR;
            xfer = T_ABORT;
         end else if (step_hit) begin
            if (cs[N_STAGES]) begin
               ns   = (WRAP != 0 && bus.go) ? ST_S1 : ST_IDLE;
               xfer = T_EXIT;
            end else begin
               ns   = cs << 1;
               xfer = T_ADVANCE;
            end
         end else if (TIMEOUT != 0 && dwell == TO_LAST) begin
            ns   = ST_ERR;
            xfer = T_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs      <= ST_IDLE;
         dwell   <= '0;
         stage_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         cause_r <= 2'b00;
         loop_r  <= '0;
      end else begin
         cs <= ns;
         // Any stage entry or exit clears the dwell; only a held stage counts.
         if (TIMEOUT != 0 && in_stage && xfer == T_HOLD) begin
            dwell <= dwell + 1'b1;
         end else begin
            dwell <= '0;
         end
         stage_r <= ns[N_STAGES:1];
         busy_r  <= |ns[N_STAGES:1];
         err_r   <= ns[ERR_B];
         done_r  <= (xfer == T_EXIT);
         case (xfer)
            T_ABORT:   cause_r <= 2'b01;
            T_TIMEOUT: cause_r <= 2'b10;
            T_ILLEGAL: cause_r <= 2'b11;
            T_RESTART: cause_r <= 2'b00;
            default:   cause_r <= cause_r;
         endcase
         case (xfer)
            T_START, T_RESTART: loop_r <= '0;
            T_EXIT: begin
               if (loop_r != '1) begin
                  loop_r <= loop_r + 1'b1;
               end
            end
            default: loop_r <= loop_r;
         endcase
      end
   end

   assign bus.stage_o   = stage_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.err_cause = cause_r;
   assign bus.loop_cnt  = loop_r;

endmodule

// File: tb/tb_fsm_onehot_chain.sv
// tb/tb_fsm_onehot_chain.sv - self-checking bench for fsm_onehot_chain (non-wrapping and wrapping instances)

module tb_fsm_onehot_chain;

   localparam int N    = 4;
   localparam int TO   = 5;
   localparam int M_IDLE = 0;
   localparam int M_ERR  = 99;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go = 1'b0;
   logic [N-1:0] step = '0;
   logic       abort = 1'b0;
   logic       restart = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model, index 0 = no wrap / LOOP_W 3, index 1 = wrap / LOOP_W 2.
   int ms    [2];
   int mdwell[2];
   int mcause[2];
   int mloop [2];
   int mdone [2];
   int mwrap [2] = '{0, 1};
   int mlmax [2] = '{7, 3};

   fsm_onehot_chain_if #(.N_STAGES(N), .LOOP_W(3)) bus0 ();
   fsm_onehot_chain_if #(.N_STAGES(N), .LOOP_W(2)) bus1 ();

   assign bus0.go = go;
   assign bus0.step = step;
   assign bus0.abort = abort;
   assign bus0.restart = restart;
   assign bus1.go = go;
   assign bus1.step = step;
   assign bus1.abort = abort;
   assign bus1.restart = restart;

   fsm_onehot_chain #(.N_STAGES(N), .TIMEOUT(TO), .TO_W(4), .WRAP(0), .LOOP_W(3)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );
   fsm_onehot_chain #(.N_STAGES(N), .TIMEOUT(TO), .TO_W(4), .WRAP(1), .LOOP_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         ms[d] = M_IDLE; mdwell[d] = 0; mcause[d] = 0; mloop[d] = 0; mdone[d] = 0;
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         mdone[d] = 0;
         if (ms[d] == M_IDLE) begin
            if (go) begin
               ms[d] = 1; mdwell[d] = 0; mloop[d] = 0;
            end
         end else if (ms[d] == M_ERR) begin
            if (restart) begin
               ms[d] = M_IDLE; mcause[d] = 0; mloop[d] = 0;
            end
         end else if (abort) begin
            ms[d] = M_ERR; mcause[d] = 1;
         end else if (step[ms[d]-1]) begin
            mdwell[d] = 0;
            if (ms[d] < N) begin
               ms[d] = ms[d] + 1;
            end else begin
               mdone[d] = 1;
               if (mloop[d] < mlmax[d]) mloop[d] = mloop[d] + 1;
               ms[d] = (mwrap[d] == 1 && go) ? 1 : M_IDLE;
            end
         end else if (mdwell[d] == TO - 1) begin
            ms[d] = M_ERR; mcause[d] = 2;
         end else begin
            mdwell[d] = mdwell[d] + 1;
         end
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] gs [2];
      logic         gb [2];
      logic         gd [2];
      logic         ge [2];
      logic [1:0]   gc [2];
      logic [2:0]   gl [2];
      logic [N-1:0] es;
      gs[0] = bus0.stage_o; gb[0] = bus0.busy; gd[0] = bus0.done;
      ge[0] = bus0.err; gc[0] = bus0.err_cause; gl[0] = bus0.loop_cnt;
      gs[1] = bus1.stage_o; gb[1] = bus1.busy; gd[1] = bus1.done;
      ge[1] = bus1.err; gc[1] = bus1.err_cause; gl[1] = {1'b0, bus1.loop_cnt};
      for (int d = 0; d < 2; d++) begin
         es = (ms[d] >= 1 && ms[d] <= N) ? N'(1 << (ms[d] - 1)) : '0;
         check_eq($sformatf("d%0d stage_o", d), 32'(gs[d]), 32'(es));
         check_eq($sformatf("d%0d busy", d), 32'(gb[d]), 32'(ms[d] >= 1 && ms[d] <= N));
         check_eq($sformatf("d%0d done", d), 32'(gd[d]), 32'(mdone[d]));
         check_eq($sformatf("d%0d err", d), 32'(ge[d]), 32'(ms[d] == M_ERR));
         check_eq($sformatf("d%0d err_cause", d), 32'(gc[d]), 32'(mcause[d]));
         check_eq($sformatf("d%0d loop_cnt", d), 32'(gl[d]), 32'(mloop[d]));
      end
   endtask

   // One clock: model consumes the inputs the DUT samples, outputs checked 1 time unit later.
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      go = 1'b0; step = '0; abort = 1'b0; restart = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int done_seen;

   initial begin
      model_reset();
      do_reset();
      check_eq("reset stage_o", 32'(bus0.stage_o), 32'h0);
      check_eq("reset loop_cnt", 32'(bus0.loop_cnt), 32'h0);

      // Straight walk through all stages.
      go = 1'b1; tick(); go = 1'b0;
      check_eq("walk s1", 32'(bus0.stage_o), 32'h1);
      for (int k = 0; k < N; k++) begin
         step = N'(1 << k);
         tick();
      end
      step = '0;
      check_eq("walk end stage", 32'(bus0.stage_o), 32'h0);
      check_eq("walk done", 32'(bus0.done), 32'h1);
      check_eq("walk busy", 32'(bus0.busy), 32'h0);
      check_eq("walk loop", 32'(bus0.loop_cnt), 32'h1);
      tick();
      check_eq("walk done pulse", 32'(bus0.done), 32'h0);

      // Timeout after exactly TO cycles held in S1.
      go = 1'b1; tick(); go = 1'b0;
      for (int c = 1; c < TO; c++) begin
         tick();
         check_eq("hold no err", 32'(bus0.err), 32'h0);
      end
      tick();
      check_eq("timeout err", 32'(bus0.err), 32'h1);
      check_eq("timeout cause", 32'(bus0.err_cause), 32'h2);
      restart = 1'b1; tick(); restart = 1'b0;

      // Step on the timeout cycle wins.
      go = 1'b1; tick(); go = 1'b0;
      for (int c = 1; c < TO; c++) tick();
      step = 4'b0001; tick(); step = '0;
      check_eq("late step stage", 32'(bus0.stage_o), 32'h2);
      check_eq("late step err", 32'(bus0.err), 32'h0);

      // Abort beats step in S3, restart clears.
      do_reset();
      go = 1'b1; tick(); go = 1'b0;
      step = 4'b0001; tick();
      step = 4'b0010; tick();
      abort = 1'b1; step = 4'b0100; tick();
      abort = 1'b0; step = '0;
      check_eq("abort err", 32'(bus0.err), 32'h1);
      check_eq("abort cause", 32'(bus0.err_cause), 32'h1);
      restart = 1'b1; tick(); restart = 1'b0;
      check_eq("restart err", 32'(bus0.err), 32'h0);
      check_eq("restart cause", 32'(bus0.err_cause), 32'h0);

      // Wrap mode looping with go and all step bits held.
      do_reset();
      done_seen = 0;
      go = 1'b1; step = '1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus1.done) done_seen++;
      end
      idle_inputs();
      check_eq("wrap done count", 32'(done_seen), 32'd4);
      check_eq("wrap loop sat", 32'(bus1.loop_cnt), 32'd3);

      // Illegal state recovery (all-zero, then IDLE|S2).
      do_reset();
      force dut0.cs = 6'b000000;
      ms[0] = M_ERR; mcause[0] = 3;
      tick();
      release dut0.cs;
      check_eq("illegal zero cause", 32'(bus0.err_cause), 32'h3);
      go = 1'b1; step = '1; tick(); tick(); idle_inputs();
      check_eq("illegal stays err", 32'(bus0.err), 32'h1);
      restart = 1'b1; tick(); restart = 1'b0;
      force dut0.cs = 6'b000101;
      ms[0] = M_ERR; mcause[0] = 3;
      tick();
      release dut0.cs;
      check_eq("illegal twohot cause", 32'(bus0.err_cause), 32'h3);
      tick();
      restart = 1'b1; tick(); restart = 1'b0;
      check_eq("illegal recovered", 32'(bus0.err), 32'h0);

      // Reset wins over abort mid-stage.
      go = 1'b1; tick(); go = 1'b0;
      step = 4'b0001; tick(); step = '0;
      rst = 1'b1; abort = 1'b1; tick(); rst = 1'b0; abort = 1'b0;
      check_eq("rst mid err", 32'(bus0.err), 32'h0);
      check_eq("rst mid stage", 32'(bus0.stage_o), 32'h0);

      // Randomised traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         rst     = ($urandom_range(0, 99) == 0);
         go      = 1'($urandom);
         step    = N'($urandom) & N'($urandom);
         abort   = ($urandom_range(0, 19) == 0);
         restart = ($urandom_range(0, 3) == 0);
         tick();
      end
      rst = 1'b0;
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_onehot_chain.md
# fsm_onehot_chain

Parametrised one-hot sequencing FSM. It walks an N-stage chain IDLE → S1 … SN under per-stage advance requests. Compared with the fixed toy FSMs in this area, it adds:
- per-stage dwell timeout;
- abort;
- illegal-state (non-one-hot) recovery;
- an optional wrap (looping) mode with a loop counter.

All outputs are registered and decoded from the next state, so they are aligned with the state register. It is the reusable control core for multi-phase sequencers in this codebase.

## Interface
Parameters:
- N_STAGES, 4, number of working stages S1..SN; legal range 2..16.
- TIMEOUT, 255, max cycles allowed in one stage without advance; 0 disables timeout.
- TO_W, 8, dwell counter width; must satisfy 2^TO_W ≥ TIMEOUT.
- WRAP, 0, 0 = return to IDLE after SN; 1 = loop back to S1 while go is held.
- LOOP_W, 8, loop counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request in IDLE; in WRAP mode, also the continue-looping qualifier at SN.
- step  in  N_STAGES  step[k-1] advances out of stage Sk; other bits ignored.
- abort  in  1  forces ERROR from any working stage.
- restart  in  1  leaves ERROR to IDLE.
- stage_o  out  N_STAGES  one-hot active stage (bit k-1 = Sk); all-zero in IDLE/ERROR.
- busy  out  1  high in any Sk.
- done  out  1  one-cycle pulse on exit from SN via step.
- err  out  1  high while in ERROR.
- err_cause  out  2  00 none, 01 abort, 10 timeout, 11 illegal state; valid while err=1.
- loop_cnt  out  LOOP_W  completed passes through SN, saturating.

## Operation
- State register CS is one-hot, N_STAGES+2 bits: IDLE, S1..SN, ERROR. NS is combinational, and the case is full and parallel.
- Illegal state: if CS is not exactly one-hot, NS=ERROR with cause 11. This has highest priority and applies regardless of other inputs.
- IDLE:
  - go=1 → S1, clearing loop_cnt.
  - Otherwise stay. abort and step are ignored.
- Sk priority is abort > step[k-1] > timeout > hold.
  - abort → ERROR, cause 01.
  - step[k-1] with k<N → S(k+1).
  - step[N-1] at SN:
    - WRAP=0 → IDLE.
    - WRAP=1 and go=1 → S1.
    - WRAP=1 and go=0 → IDLE.
    - In every case done pulses and loop_cnt increments, saturating at all-ones.
  - Timeout, TIMEOUT≠0: the dwell counter clears on entry to any stage. Each held cycle:
    - dwell == TIMEOUT-1 → ERROR, cause 10.
    - Otherwise dwell increments.
    - This gives at most TIMEOUT cycles in a stage.
- ERROR:
  - restart=1 → IDLE, clearing err_cause and loop_cnt.
  - Otherwise stay, and err_cause is held.
- Outputs (stage_o, busy, done, err, err_cause, loop_cnt) are registered from NS and the transition decision. Every output defaults to 0/unchanged each cycle unless the NS decode sets it.

## Timing
- Reset:
  - CS=IDLE, dwell=0.
  - stage_o=0, busy=0, done=0, err=0, err_cause=00, loop_cnt=0.
  - rst overrides every input, including mid-stage, and takes effect on the next edge.
- Latency: an input sampled at edge t is reflected in CS and in all outputs after edge t. Outputs never lag CS.
- Back-to-back steps:
  - One stage is traversed per cycle.
  - step bits for non-current stages have no effect.
  - A step held high advances once per cycle.
- Simultaneous events:
  - abort+step → ERROR, cause 01.
  - step on the timeout cycle → advance, no error.
  - restart outside ERROR is ignored.
  - go in working stages matters only at the SN exit in WRAP mode.
- Timeout count: entering Sk at edge t with no step or abort gives ERROR at edge t+TIMEOUT.

## Test plan
- Reset, N_STAGES=4: go=1 one cycle, then step[0..3] on successive cycles → stage_o goes 0001, 0010, 0100, 1000, 0000. done=1 for exactly one cycle as busy falls, and loop_cnt=1.
- TIMEOUT=5, go then hold in S1 → err=1, err_cause=10, stage_o=0 exactly 5 cycles after S1 entry. Repeat with step[0] in the 5th cycle → S2, no error.
- In S3, assert abort and step[2] together → ERROR, cause 01. restart=1 → IDLE next cycle, err=0, err_cause=00, loop_cnt=0.
- WRAP=1, LOOP_W=2, go held, step held all-ones → continuous S1..S4 looping. loop_cnt goes 1, 2, 3 and stays 3, with a done pulse at every SN exit.
- Force CS to 0 and to two-hot (IDLE|S2) → next cycle ERROR, err_cause=11, and only restart recovers.
- Assert rst in S2 while abort=1 → IDLE and all outputs zero after one edge, with no ERROR entry.
